// File: rtl/sdram_rd_if.sv
// Request/return bundle between the SDRAM arbiter and the page-burst read engine.
// The master side is the arbiter; the slave side is sdram_rd_burst_ctrl.
interface sdram_rd_if #(
    parameter int DQ_W  = 16,
    parameter int BA_W  = 2,
    parameter int ROW_W = 13,
    parameter int COL_W = 9,
    parameter int LEN_W = 10
) ();
    logic                         init_end;
    logic                         rd_en;
    logic [BA_W+ROW_W+COL_W-1:0]  rd_addr;
    logic [LEN_W-1:0]             rd_burst_len;
    logic [DQ_W-1:0]              sdram_dq_in;
    logic                         rd_busy;
    logic                         rd_ack;
    logic [DQ_W-1:0]              rd_data;
    logic                         rd_data_vld;
    logic                         rd_end;
    logic [3:0]                   read_cmd;
    logic [BA_W-1:0]              read_ba;
    logic [ROW_W-1:0]             read_addr;

    modport master (
        output init_end, rd_en, rd_addr, rd_burst_len, sdram_dq_in,
        input  rd_busy, rd_ack, rd_data, rd_data_vld, rd_end, read_cmd, read_ba, read_addr
    );

    modport slave (
        input  init_end, rd_en, rd_addr, rd_burst_len, sdram_dq_in,
        output rd_busy, rd_ack, rd_data, rd_data_vld, rd_end, read_cmd, read_ba, read_addr
    );
endinterface

// File: rtl/sdram_rd_burst_ctrl.sv
// Page-burst SDRAM read engine: ACTIVE, READ, optional BURST STOP, PRECHARGE, with data return.
// state | meaning: IDLE wait req | ACT row open | TRCD wait | RD read cmd | CL wait | DATA words | PRE precharge | TRP wait | END done pulse
module sdram_rd_burst_ctrl #(
    parameter int DQ_W  = 16,
    parameter int BA_W  = 2,
    parameter int ROW_W = 13,
    parameter int COL_W = 9,
    parameter int LEN_W = 10,
    parameter int TRCD  = 2,
    parameter int CL    = 3,
    parameter int TRP   = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    sdram_rd_if.slave  rd_if
);
    localparam int CNT_W = LEN_W + 2;

    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_BSTOP = 4'b0110;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_NOP   = 4'b0111;

    localparam logic [LEN_W-1:0] PAGE_LEN  = LEN_W'(2 ** COL_W);
    localparam logic [CNT_W-1:0] TRCD_LAST = CNT_W'(TRCD - 2);
    localparam logic [CNT_W-1:0] CL_LAST   = CNT_W'(CL - 2);
    localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'(TRP - 2);
    localparam logic [CNT_W-1:0] CL_CNT    = CNT_W'(CL);
    localparam logic [ROW_W-1:0] A10       = ROW_W'(1 << 10);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_TRCD,
        S_RD,
        S_CL,
        S_DATA,
        S_PRE,
        S_TRP,
        S_END
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BA_W-1:0]    bank_q, bank_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [BA_W-1:0]    ba_q, ba_d;
    logic [ROW_W-1:0]   addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic [DQ_W-1:0]    data_q, data_d;
    logic               vld_q, vld_d;
    logic               end_q, end_d;

    logic               req;
    logic               accept;
    logic               full_page;
    logic               bstop;
    logic [CNT_W-1:0]   len_x;
    logic [ROW_W-1:0]   rd_col;

    always_comb begin
        req       = rd_if.init_end && rd_if.rd_en && (rd_if.rd_burst_len != '0);
        accept    = req && ((state_q == S_IDLE) || (state_q == S_END));
        len_x     = {2'b00, len_q};
        full_page = (len_q == PAGE_LEN);

        state_d = state_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        len_d   = len_q;

        unique case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_ACT:  state_d = (TRCD == 1) ? S_RD : S_TRCD;
            S_TRCD: if (cnt_q == TRCD_LAST) state_d = S_RD;
            S_RD:   state_d = S_CL;
            S_CL:   if (cnt_q == CL_LAST) state_d = S_DATA;
            S_DATA: if (cnt_q == len_x - 1'b1) state_d = S_PRE;
            S_PRE:  state_d = (TRP == 1) ? S_END : S_TRP;
            S_TRP:  if (cnt_q == TRP_LAST) state_d = S_END;
            S_END:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // END also samples the request so a held rd_en re-opens the row right after rd_end
        if (accept) begin
            state_d = S_ACT;
            bank_d  = rd_if.rd_addr[BA_W+ROW_W+COL_W-1 -: BA_W];
            row_d   = rd_if.rd_addr[ROW_W+COL_W-1 -: ROW_W];
            col_d   = rd_if.rd_addr[COL_W-1:0];
            len_d   = (rd_if.rd_burst_len > PAGE_LEN) ? PAGE_LEN : rd_if.rd_burst_len;
        end

        cnt_d = '0;
        if ((state_d == state_q) && (state_q != S_IDLE)) cnt_d = cnt_q + 1'b1;

        // Outputs are computed for the state being entered, so the registered command lines up with it.
        // BURST STOP lands TRCD+L after ACTIVE: inside the CL wait for short bursts, else inside DATA.
        bstop = !full_page &&
                (((state_d == S_CL) && (cnt_d == len_x - 1'b1)) ||
                 ((state_d == S_DATA) && (len_x >= CL_CNT) && (cnt_d == len_x - CL_CNT)));

        rd_col = {{(ROW_W-COL_W){1'b0}}, col_q} & ~A10;

        cmd_d  = CMD_NOP;
        ba_d   = ba_q;
        addr_d = addr_q;
        if (state_d == S_ACT) begin
            cmd_d  = CMD_ACT;
            ba_d   = bank_d;
            addr_d = row_d;
        end else if (state_d == S_RD) begin
            cmd_d  = CMD_READ;
            ba_d   = bank_q;
            addr_d = rd_col;
        end else if (state_d == S_PRE) begin
            cmd_d  = CMD_PRE;
            addr_d = A10;
        end else if (bstop) begin
            cmd_d  = CMD_BSTOP;
            addr_d = '0;
        end

        busy_d = (state_d != S_IDLE);
        ack_d  = (state_d == S_DATA);
        end_d  = (state_d == S_END);
        vld_d  = ack_q;
        data_d = ack_q ? rd_if.sdram_dq_in : data_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            len_q   <= '0;
            cmd_q   <= CMD_NOP;
            ba_q    <= '0;
            addr_q  <= '1;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
            len_q   <= len_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            end_q   <= end_d;
        end
    end

    assign rd_if.read_cmd    = cmd_q;
    assign rd_if.read_ba     = ba_q;
    assign rd_if.read_addr   = addr_q;
    assign rd_if.rd_busy     = busy_q;
    assign rd_if.rd_ack      = ack_q;
    assign rd_if.rd_data     = data_q;
    assign rd_if.rd_data_vld = vld_q;
    assign rd_if.rd_end      = end_q;

endmodule
